// File: rtl/riptide_pkg.sv
// Shared RIPTIDE_II definitions: bus widths, program-cache FSM states and
// address-field helpers used by the instruction cache.
package riptide_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StFill,
        StUpdate,
        StFlush
    } pcache_state_t;

    // Field extractors return full-width values; callers cast to the field width.
    function automatic logic [ADDR_W-1:0] tag_of(input logic [ADDR_W-1:0] a,
                                                 input int unsigned tag_lo);
        return a >> tag_lo;
    endfunction

    function automatic logic [ADDR_W-1:0] index_of(input logic [ADDR_W-1:0] a,
                                                   input int unsigned off_w,
                                                   input int unsigned idx_w);
        return (a >> off_w) & ((16'(1) << idx_w) - 16'(1));
    endfunction

    function automatic logic [ADDR_W-1:0] offset_of(input logic [ADDR_W-1:0] a,
                                                    input int unsigned off_w);
        return a & ((16'(1) << off_w) - 16'(1));
    endfunction

endpackage

// File: rtl/pcache_ram.sv
// Tag + data synchronous RAM pair for the program cache. Registered read port,
// separate write ports; a tag write to the line being read is forwarded.
module pcache_ram #(
    parameter int unsigned INDEX_W  = 6,
    parameter int unsigned OFFSET_W = 2,
    parameter int unsigned TAG_W    = 8,
    parameter int unsigned DATA_W   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [INDEX_W-1:0]           rd_line_i,
    input  logic [OFFSET_W-1:0]          rd_off_i,
    input  logic                         tag_we_i,
    input  logic [INDEX_W-1:0]           tag_wr_line_i,
    input  logic [TAG_W-1:0]             tag_wdata_i,
    input  logic                         data_we_i,
    input  logic [INDEX_W+OFFSET_W-1:0]  data_wr_addr_i,
    input  logic [DATA_W-1:0]            data_wdata_i,
    output logic [TAG_W-1:0]             tag_rdata_o,
    output logic [DATA_W-1:0]            data_rdata_o
);

    logic [TAG_W-1:0]  tag_mem  [2**INDEX_W];
    logic [DATA_W-1:0] data_mem [2**(INDEX_W+OFFSET_W)];

    always_ff @(posedge clk_i) begin
        if (tag_we_i) begin
            tag_mem[tag_wr_line_i] <= tag_wdata_i;
        end
        if (data_we_i) begin
            data_mem[data_wr_addr_i] <= data_wdata_i;
        end
    end

    // Forwarding lets the install cycle read back the tag it is writing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_rdata_o  <= '0;
            data_rdata_o <= '0;
        end else begin
            tag_rdata_o  <= (tag_we_i && tag_wr_line_i == rd_line_i) ? tag_wdata_i
                                                                     : tag_mem[rd_line_i];
            data_rdata_o <= data_mem[{rd_line_i, rd_off_i}];
        end
    end

endmodule

// File: rtl/prog_cache.sv
// Direct-mapped read-only instruction cache for the RIPTIDE_II fetch port.
// Define PCACHE_FLUSH_EN to add the flush input and the FLUSH sweep state.
module prog_cache
    import riptide_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LINES      = 64
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] I,
    output logic              p_cache_miss,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_address,
    input  logic              mem_ack,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data
`ifdef PCACHE_FLUSH_EN
    ,
    input  logic              flush
`endif
);

    localparam int unsigned OFFSET_W = $clog2(LINE_WORDS);
    localparam int unsigned INDEX_W  = $clog2(LINES);
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    pcache_state_t       state_q;
    logic [ADDR_W-1:0]   a_q;
    logic [LINES-1:0]    valid_q;
    logic [OFFSET_W-1:0] cnt_q;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_addr_q;

    logic [INDEX_W-1:0]  a_idx, in_idx, rd_line;
    logic [OFFSET_W-1:0] a_off, in_off, rd_off;
    logic [TAG_W-1:0]    a_tag, tag_rd;
    logic                hit, flush_go, advance;

    assign a_idx  = INDEX_W'(index_of(a_q, OFFSET_W, INDEX_W));
    assign a_off  = OFFSET_W'(offset_of(a_q, OFFSET_W));
    assign a_tag  = TAG_W'(tag_of(a_q, OFFSET_W + INDEX_W));
    assign in_idx = INDEX_W'(index_of(A, OFFSET_W, INDEX_W));
    assign in_off = OFFSET_W'(offset_of(A, OFFSET_W));

`ifdef PCACHE_FLUSH_EN
    logic               flush_pend_q;
    logic [INDEX_W-1:0] flush_idx_q;
    assign flush_go = (state_q == StIdle) && (flush || flush_pend_q);
`else
    assign flush_go = 1'b0;
`endif

    assign hit     = valid_q[a_idx] && (tag_rd == a_tag);
    // Only a hitting lookup moves on to A; otherwise re-read the frozen A_q.
    assign advance = (state_q == StIdle) && hit && !flush_go;
    assign rd_line = advance ? in_idx : a_idx;
    assign rd_off  = advance ? in_off : a_off;

    assign p_cache_miss = !hit || (state_q != StIdle);
    assign mem_req      = mem_req_q;
    assign mem_address  = mem_addr_q;

    pcache_ram #(
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .TAG_W    (TAG_W),
        .DATA_W   (DATA_W)
    ) u_ram (
        .clk_i          (clk),
        .rst_i          (RST),
        .rd_line_i      (rd_line),
        .rd_off_i       (rd_off),
        .tag_we_i       (state_q == StUpdate),
        .tag_wr_line_i  (a_idx),
        .tag_wdata_i    (a_tag),
        .data_we_i      ((state_q == StFill) && mem_data_valid),
        .data_wr_addr_i ({a_idx, cnt_q}),
        .data_wdata_i   (mem_data),
        .tag_rdata_o    (tag_rd),
        .data_rdata_o   (I)
    );

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            a_q        <= '0;
            valid_q    <= '0;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
`ifdef PCACHE_FLUSH_EN
            flush_pend_q <= 1'b0;
            flush_idx_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (flush_go) begin
`ifdef PCACHE_FLUSH_EN
                        state_q      <= StFlush;
                        flush_idx_q  <= '0;
                        flush_pend_q <= 1'b0;
`endif
                    end else if (hit) begin
                        a_q <= A;
                    end else begin
                        state_q    <= StReq;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= a_q & ~((16'(1) << OFFSET_W) - 16'(1));
                    end
                end
                StReq: begin
                    if (mem_ack) begin
                        state_q   <= StFill;
                        mem_req_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                StFill: begin
                    if (mem_data_valid) begin
                        cnt_q <= cnt_q + OFFSET_W'(1);
                        if (cnt_q == OFFSET_W'(LINE_WORDS - 1)) begin
                            state_q <= StUpdate;
                        end
                    end
                end
                StUpdate: begin
                    valid_q[a_idx] <= 1'b1;
                    state_q        <= StIdle;
                end
`ifdef PCACHE_FLUSH_EN
                StFlush: begin
                    valid_q[flush_idx_q] <= 1'b0;
                    flush_idx_q          <= flush_idx_q + INDEX_W'(1);
                    if (flush_idx_q == INDEX_W'(LINES - 1)) begin
                        state_q <= StIdle;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
`ifdef PCACHE_FLUSH_EN
            // A flush arriving mid-refill is remembered until IDLE.
            if (flush && (state_q inside {StReq, StFill, StUpdate})) begin
                flush_pend_q <= 1'b1;
            end
`endif
        end
    end

endmodule
